// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between instruction fetch and load/store,
// data-first with a fairness counter, and decodes ROM/RAM windows into ok/error responses.
module memory_port_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE     = 32'h00400000,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = 32'h10010000,
  parameter int                    READ_LATENCY = 1,
  parameter int                    MAX_D_GRANTS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ack_o,
  output logic                  if_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic                  mem_write_enable_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam int FW = $clog2(MAX_D_GRANTS + 1);
  localparam logic [DATA_WIDTH-1:0] WIN  = DATA_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [FW-1:0]         MAXF = FW'(MAX_D_GRANTS);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                r_state;
  logic                  r_own_d;
  logic                  r_we;
  logic [CW-1:0]         r_cnt;
  logic [FW-1:0]         r_fair;
  logic                  w_grant;
  logic                  w_sel_d;
  logic                  w_we;
  logic                  w_legal;
  logic [DATA_WIDTH-1:0] w_addr;
  assign w_grant = if_req_i | d_req_i;
  assign w_sel_d = d_req_i & (~if_req_i | (r_fair != MAXF));
  assign w_addr  = w_sel_d ? d_addr_i : if_addr_i;
  assign w_we    = w_sel_d & d_we_i;
  // unsigned wrap of (addr - base) makes a single compare cover both window edges
  assign w_legal = (w_addr[1:0] == 2'b00) &&
                   (((w_addr - RAM_BASE) < WIN) || (((w_addr - ROM_BASE) < WIN) && !w_we));
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state            <= IDLE;
      r_own_d            <= 1'b0;
      r_we               <= 1'b0;
      r_cnt              <= '0;
      r_fair             <= '0;
      if_rdata_o         <= '0;
      if_ack_o           <= 1'b0;
      if_err_o           <= 1'b0;
      d_rdata_o          <= '0;
      d_ack_o            <= 1'b0;
      d_err_o            <= 1'b0;
      mem_address_o      <= '0;
      mem_write_enable_o <= 1'b0;
      mem_write_data_o   <= '0;
    end else begin
      if_ack_o           <= 1'b0;
      if_err_o           <= 1'b0;
      d_ack_o            <= 1'b0;
      d_err_o            <= 1'b0;
      mem_write_enable_o <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_own_d <= w_sel_d;
          r_we    <= w_we;
          r_fair  <= (w_sel_d && if_req_i) ? ((r_fair == MAXF) ? r_fair : r_fair + 1'b1) : '0;
          if (w_legal) begin
            mem_address_o      <= w_addr;
            mem_write_data_o   <= d_wdata_i;
            mem_write_enable_o <= w_we;
            r_cnt              <= CW'(READ_LATENCY - 1);
            r_state            <= ACCESS;
          end else begin
            r_state <= RESP;
            if (w_sel_d) begin
              d_ack_o   <= 1'b1;
              d_err_o   <= 1'b1;
              d_rdata_o <= '0;
            end else begin
              if_ack_o   <= 1'b1;
              if_err_o   <= 1'b1;
              if_rdata_o <= '0;
            end
          end
        end
        ACCESS: if (r_cnt == '0) begin
          r_state <= RESP;
          if (r_own_d) begin
            d_ack_o   <= 1'b1;
            d_rdata_o <= r_we ? '0 : mem_read_data_i;
          end else begin
            if_ack_o   <= 1'b1;
            if_rdata_o <= mem_read_data_i;
          end
        end else r_cnt <= r_cnt - 1'b1;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
